// File: rtl/combo_pkg.sv
// Types and widths shared between combo_logic and its upstream operation sequencer.
package combo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [CTRL_W-1:0] control_in;
  } input_port;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
  } output_port;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} seq_state_e;

endpackage

// File: rtl/combo_op_fifo.sv
// Synchronous FIFO of packed operation requests; extra pointer MSB separates full from empty.
module combo_op_fifo
  import combo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  input_port wdata,
  output input_port rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0] wptr_q, rptr_q;
  input_port   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
  end

  always_comb begin
    rdata = mem[rptr_q[AW-1:0]];
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  end

endmodule

// File: rtl/combo_op_sequencer.sv
// Buffers operation requests and issues them one at a time onto the combo_logic input register.
module combo_op_sequencer
  import combo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output input_port         p1,
  output logic              p1_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  seq_state_e       state_q;
  input_port        p1_q;
  logic             p1_valid_q;
  logic [CNT_W-1:0] cnt_q;
  input_port        head;
  logic             full, empty, push, load, consume;

  always_comb begin
    in_ready = !full && (state_q != FLUSH);
    push     = in_valid && in_ready;
    load     = !empty && (!p1_valid_q || out_ready) && (state_q != FLUSH);
    consume  = p1_valid_q && out_ready;
    busy     = (state_q != IDLE);
    p1       = p1_q;
    p1_valid = p1_valid_q;
    issue_cnt = cnt_q;
  end

  combo_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (load),
    .clear (state_q == FLUSH),
    .wdata ({in_a, in_b, in_ctrl}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p1_q       <= '0;
      p1_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // p1 data is kept on flush so combo_logic inputs stay defined
      if (load) p1_q <= head;

      if (flush || state_q == FLUSH) p1_valid_q <= 1'b0;
      else if (load)                 p1_valid_q <= 1'b1;
      else if (consume)              p1_valid_q <= 1'b0;

      if (consume && cnt_q != '1) cnt_q <= cnt_q + CntOne;

      unique case (state_q)
        IDLE: begin
          if (flush)     state_q <= FLUSH;
          else if (push) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (flush)                          state_q <= FLUSH;
          else if (empty && !push && consume) state_q <= IDLE;
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/combo_op_sequencer.md
# combo_op_sequencer

Upstream feeder for `combo_logic`. It accepts operation requests (operand A, operand B, control code) over a valid/ready handshake and buffers them in a 4-entry FIFO. It issues one registered operation at a time onto the `input_port` struct that drives `combo_logic`. It also tracks how many operations were issued, and supports a synchronous flush.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: width of the issued-operation counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_a`  in  `DATA_W`  operand A.
- `in_b`  in  `DATA_W`  operand B.
- `in_ctrl`  in  `CTRL_W`  operation select.
- `flush`  in  1  synchronous clear of queued and pending operations.
- `p1`  out  `input_port`  registered `a_in`/`b_in`/`control_in` to `combo_logic`.
- `p1_valid`  out  1  `p1` holds an unconsumed operation.
- `out_ready`  in  1  downstream result capture consumes `p1` this cycle.
- `issue_cnt`  out  `CNT_W`  count of operations consumed downstream; saturating.
- `busy`  out  1  state is not IDLE.

## Operation
- **Reset values:** `p1` all zero, `p1_valid`=0, FIFO empty, `issue_cnt`=0, state IDLE. As a result, `in_ready`=1 and `busy`=0.
- **Input side:**
  - `in_ready = !full && state != FLUSH`.
  - A push writes {`in_a`, `in_b`, `in_ctrl`} at the tail.
- **Issue (load) condition:** `load = !empty && (!p1_valid || out_ready) && state != FLUSH`.
  - On `load`, pop the head into `p1` and set `p1_valid`=1.
- **Consume without reload:** on `p1_valid && out_ready && !load`, `p1_valid` goes to 0.
  - `p1` fields keep their last value, so `combo_logic` inputs never glitch to X.
- **Counter:** `issue_cnt` increments on every `p1_valid && out_ready`. It saturates at all-ones and does not wrap.
- **Simultaneous push and pop:** allowed in the same cycle, including when full. When full, `in_ready` is still 0, so no push happens that cycle; the pop frees the slot for the next cycle. Occupancy is unchanged on a simultaneous push and pop.
- **No bypass:** a push into an empty FIFO is never loaded into `p1` in the same cycle.
- **State machine:**
  - IDLE: FIFO empty and `p1_valid`=0.
    - Goes to ACTIVE on a push.
    - Goes to FLUSH on `flush`.
  - ACTIVE: FIFO non-empty or `p1_valid`=1.
    - Returns to IDLE when the last pending operation is consumed with the FIFO empty and no push in that cycle.
    - Goes to FLUSH on `flush`.
  - FLUSH: lasts exactly one cycle.
    - Clears the FIFO pointers and count, and sets `p1_valid`=0. `p1` data is retained.
    - `in_ready`=0 during this cycle.
    - Next state is always IDLE.
- **Flush priority:**
  - The flush is registered: it takes effect at the edge where `flush`=1 is sampled, and the one-cycle FLUSH state clears the queue.
  - In the cycle `flush` is sampled, the push and load happen normally; everything is then discarded by the FLUSH state.
  - A consume (`p1_valid && out_ready`) in the cycle `flush` is sampled still increments `issue_cnt`.
  - `flush` does not clear `issue_cnt`; only reset does.
- **Asynchronous reset:** asserting `rst_n` mid-operation immediately returns every output to its reset value and discards all queued entries.

## Timing
- **Push-to-issue latency:** 2 edges into an empty block.
  - Push at edge N; `p1`/`p1_valid` are updated at edge N+1.
- **Throughput:** one operation per cycle while the FIFO is non-empty and `out_ready`=1.
- **Stall behaviour:**
  - While `p1_valid`=1 and `out_ready`=0, `p1` is held stable.
  - The FIFO keeps accepting until full (DEPTH entries).
- **Combinational paths:** `in_ready` and `busy` are decoded from registers only, with no combinational path from `in_valid`. `out_ready` affects only next-state logic.

## Structure
- **Shared package `combo_pkg`:**
  - `DATA_W` (8) and `CTRL_W` (3).
  - The `input_port` / `output_port` struct typedefs, shared with `combo_logic`.
  - A `seq_state_e` enum: IDLE, ACTIVE, FLUSH.
- **Sub-module `combo_op_fifo`:**
  - Synchronous FIFO, depth `DEPTH`, storing the packed `input_port` struct.
  - Pointers one bit wider than the address, giving full and empty detection on wrap-around.
  - Ports: push, pop, clear, full, empty.
- **Top level:** holds the FSM, the output register and the counter.

## Test plan
- **Basic issue:** push A=0x12, B=0x34, ctrl=3 into an idle block with `out_ready`=1 → two edges later `p1`={0x12, 0x34, 3} with `p1_valid`=1. One cycle after that, `p1_valid`=0, `issue_cnt`=1 and `busy`=0.
- **Backpressure:** hold `out_ready`=0 and push 5 requests → the first appears on `p1` and stays stable; the FIFO fills with 4 entries and `in_ready`=0. Release `out_ready` → all 5 issue in order on consecutive cycles, and `issue_cnt`=5.
- **Full with simultaneous pop:** with the FIFO full and `out_ready`=1, hold `in_valid`=1 → `in_ready` reasserts the cycle after the pop. Steady-state streaming then runs at 1 op/cycle with no loss, reordering or duplication, checked over 64 random ops against a scoreboard.
- **Flush:** with 3 ops queued and one pending, pulse `flush` → the next cycle is FLUSH with `in_ready`=0 and `p1_valid`=0, then IDLE. No flushed op is issued afterward, and `issue_cnt` is unchanged.
- **Reset mid-stream and counter limit:**
  - Assert `rst_n`=0 asynchronously mid-burst → all outputs are zero immediately; after release the block behaves as after power-up.
  - Force `issue_cnt` to 0xFFFE and consume 3 ops → the counter reads 0xFFFF and stays there.
